sseg_reader: RTL and testbench
==============================

Name: sseg_reader

Overview:
- Receive side of the multiplexed seven-segment display interface: samples a segment bus and one-hot digit-select strobes and recovers the displayed hex value.
- Filters glitches with a stability counter and maps each segment pattern back to a nibble.
- Assembles a full NUM_DIGITS frame and presents it on a valid/ready output.
- Used on-chip for display loopback self-test and by the bench as a display monitor.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions.
- STABLE_CYCLES, 4: consecutive identical cycles required to accept a sample; legal range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sseg_in  in  7  segment bus, active-high; bit0=a … bit6=g
- sel_in  in  NUM_DIGITS  one-hot digit select; bit i = digit i, where digit 0 is the least significant nibble
- out_value  out  4*NUM_DIGITS  assembled frame; digit i occupies bits [4i+3:4i]
- out_blank  out  NUM_DIGITS  per-digit flag: pattern was all-off, so the nibble reads 0
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts the frame
- err  out  1  sticky flag: unrecognised pattern seen
- err_clr  in  1  clears err

Behaviour:
- Reset: all outputs 0; the input stage, stability counter, shadow slots and captured mask are all cleared.
- Input stage:
  - sseg_in and sel_in are registered once.
  - The counter increments while the registered {sel, sseg} equals the previous cycle's value, saturating at STABLE_CYCLES.
  - Any change clears the counter to 0.
- Accept:
  - Exactly one accept per stable episode, in the cycle the counter first reaches STABLE_CYCLES-1.
  - sel not one-hot (zero or multiple bits set) never accepts, and the counter is held at 0.
- Pattern map (hex, active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - blank=00
- On accept of a known pattern: write the nibble and blank bit into shadow slot i, and set captured[i].
- On accept of an unknown pattern: set err; slot i and captured[i] are unchanged.
- Re-accepting a slot already captured overwrites it; the latest sample wins.
- Frame FSM, states COLLECT and PRESENT:
  - COLLECT → PRESENT when captured is all ones. On that edge, copy the shadow to out_value/out_blank, set out_valid, and clear captured.
  - PRESENT: out_value/out_blank are frozen while out_valid=1. Collection continues into the shadow.
  - PRESENT, out_ready=1 → out_valid drops next edge. If captured is all ones in the same cycle, the new frame loads instead, out_valid stays 1, and the state stays PRESENT.
  - PRESENT, out_ready=1 with captured not all ones → COLLECT.
- Latency: with the consumer ready, out_valid rises STABLE_CYCLES+2 cycles after the first cycle in which the final missing digit is presented and held.
- err: set wins over err_clr in the same cycle; otherwise err_clr clears it on the next edge.
- Reset mid-frame: everything is discarded; no partial frame is ever presented.

Optional Feature:
- Macro SSEG_READER_CHANGE_ONLY_EN.
- Defined: a completed frame whose {value, blank} equals the last presented frame is dropped silently. captured is cleared and out_valid is not raised. The comparison register resets to all ones in both fields, so the first frame after reset is always presented.
- Undefined: every completed frame is presented.

Decomposition:
- Package sseg_pkg:
  - segment bit-index constants SEG_A..SEG_G
  - typedef seg_t (logic [6:0])
  - the 16 pattern constants plus SEG_BLANK
  - typedef nibble_t
- One combinational sub-module, sseg_pattern_decode:
  - input seg_t
  - outputs known, blank and nibble_t
- Sequential logic stays in sseg_reader.

Test Plan:
- Clean scan with defaults: sel 0001..1000 hold patterns 3F,06,5B,4F for 6 cycles each, out_ready=1 → one frame, out_value=16'h3210, out_blank=0, out_valid for 1 cycle.
- Glitch: digit 0 shows 7F for 2 cycles then 6F held 5 cycles, remaining digits as above → digit 0 nibble=9, never 8.
- Unknown and blank:
  - digit 2 shows 55 for 5 cycles → err=1 and no frame; a later 00 on digit 2 completes the frame with out_blank[2]=1 and nibble 0.
  - err_clr → err=0.
- Backpressure:
  - out_ready=0 over two full scans (first A,b,C,d then E,F,0,1) → out_value stays 16'hDCBA.
  - out_ready=1 → next frame 16'h10FE follows with out_valid held high.
- Illegal select: sel=0011 or 0000 held 10 cycles with 3F → no accept, captured unchanged.
- Reset while 3 digits are captured → outputs 0; a subsequent single-digit hold produces no frame.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared segment constants and types for the seven-segment reader.
// Pattern encoding is active-high, bit0 = segment a .. bit6 = segment g.
package sseg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] nibble_t;

   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_HA    = 7'h77;
   localparam seg_t SEG_HB    = 7'h7C;
   localparam seg_t SEG_HC    = 7'h39;
   localparam seg_t SEG_HD    = 7'h5E;
   localparam seg_t SEG_HE    = 7'h79;
   localparam seg_t SEG_HF    = 7'h71;
   localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Maps a segment pattern back to its hex nibble.
// Unlisted patterns report known=0; the all-off pattern is a blank zero.
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  seg_t    seg,
   output logic    known,
   output logic    blank,
   output nibble_t nibble
);

   // reverse lookup of the display font
   always_comb begin
      known  = 1'b1;
      blank  = 1'b0;
      nibble = 4'h0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_HA:    nibble = 4'hA;
         SEG_HB:    nibble = 4'hB;
         SEG_HC:    nibble = 4'hC;
         SEG_HD:    nibble = 4'hD;
         SEG_HE:    nibble = 4'hE;
         SEG_HF:    nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   known  = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_reader.sv
// Seven-segment display monitor: debounces the mux bus and rebuilds frames.
// Define SSEG_READER_CHANGE_ONLY_EN to drop frames equal to the last one.
module sseg_reader
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              sseg_in,
   input  logic [NUM_DIGITS-1:0]   sel_in,
   output logic [4*NUM_DIGITS-1:0] out_value,
   output logic [NUM_DIGITS-1:0]   out_blank,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err,
   input  logic                    err_clr
);

   typedef enum logic {COLLECT, PRESENT} state_t;

   localparam int            CW      = 8;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 2);

   seg_t                    sseg_q;
   seg_t                    sseg_p;
   logic [NUM_DIGITS-1:0]   sel_q;
   logic [NUM_DIGITS-1:0]   sel_p;
   logic [CW-1:0]           cnt;
   logic                    same;
   logic                    onehot;
   logic                    accept;
   logic                    known;
   logic                    blank;
   nibble_t                 nib;

   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_blank;
   logic [NUM_DIGITS-1:0]   captured;
   logic                    full;
   logic                    dup;

   state_t                  state;
   state_t                  state_n;
   logic                    load;
   logic                    clr_cap;

   assign same   = (sel_q == sel_p) && (sseg_q == sseg_p);
   assign onehot = $onehot(sel_q);
   // counter moves to STABLE_CYCLES-1 on this edge: the single accept point
   assign accept = same && onehot && (cnt == CNT_ACC);
   assign full   = &captured;

   sseg_pattern_decode u_dec (
      .seg    (sseg_q),
      .known  (known),
      .blank  (blank),
      .nibble (nib)
   );

`ifdef SSEG_READER_CHANGE_ONLY_EN
   logic [4*NUM_DIGITS-1:0] last_val;
   logic [NUM_DIGITS-1:0]   last_blank;

   assign dup = (shadow_val == last_val) && (shadow_blank == last_blank);

   // remember the last frame handed out; all ones so the first always differs
   always_ff @(posedge clk) begin
      if (reset) begin
         last_val   <= '1;
         last_blank <= '1;
      end else if (load) begin
         last_val   <= shadow_val;
         last_blank <= shadow_blank;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // register the bus and measure how long it has held still
   always_ff @(posedge clk) begin
      if (reset) begin
         sseg_q <= '0;
         sseg_p <= '0;
         sel_q  <= '0;
         sel_p  <= '0;
         cnt    <= '0;
      end else begin
         sseg_q <= sseg_in;
         sel_q  <= sel_in;
         sseg_p <= sseg_q;
         sel_p  <= sel_q;
         if (!same || !onehot) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // write accepted digits into the shadow frame
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_val   <= '0;
         shadow_blank <= '0;
         captured     <= '0;
      end else begin
         if (clr_cap) begin
            captured <= '0;
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && known && sel_q[i]) begin
               shadow_val[4*i +: 4] <= nib;
               shadow_blank[i]      <= blank;
               captured[i]          <= 1'b1;
            end
         end
      end
   end

   // frame sequencing: decide when a complete shadow is handed out
   always_comb begin
      state_n = state;
      load    = 1'b0;
      clr_cap = 1'b0;
      unique case (state)
         COLLECT: begin
            if (full) begin
               clr_cap = 1'b1;
               if (!dup) begin
                  load    = 1'b1;
                  state_n = PRESENT;
               end
            end
         end
         PRESENT: begin
            if (out_ready) begin
               if (full) begin
                  clr_cap = 1'b1;
                  if (dup) begin
                     state_n = COLLECT;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  state_n = COLLECT;
               end
            end
         end
      endcase
   end

   // state register, output frame and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         out_value <= '0;
         out_blank <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            out_value <= shadow_val;
            out_blank <= shadow_blank;
         end
         if (accept && !known) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_sseg_reader.sv
// Self-checking bench for sseg_reader: directed scenarios plus random
// episodes compared against an episode-level display model.
module tb_sseg_reader;

   localparam int ND = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    sseg_in;
   logic [ND-1:0] sel_in;
   logic [4*ND-1:0] out_value;
   logic [ND-1:0] out_blank;
   logic          out_valid;
   logic          out_ready;
   logic          err;
   logic          err_clr;

   always #5 clk = ~clk;

   sseg_reader #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sseg_in   (sseg_in),
      .sel_in    (sel_in),
      .out_value (out_value),
      .out_blank (out_blank),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .err_clr   (err_clr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                            7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                            7'h39, 7'h5E, 7'h79, 7'h71};

   logic [19:0] obs_q [$];
   int valid_cycles = 0;

   always @(negedge clk) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) obs_q.push_back({out_blank, out_value});
   end

   task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
      sel_in  = s;
      sseg_in = g;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hold(4'b0000, 7'h00, 3);
      reset = 1'b0;
      obs_q.delete();
      valid_cycles = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hold(4'b0010, 7'h55, 3);
      n_checks++;
      if (out_value !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_value: got %h expected 0000", out_value);
      end
      n_checks++;
      if (out_blank !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_blank: got %b expected 0000", out_blank);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b expected 0", err);
      end
      reset = 1'b0;
      hold(4'b0000, 7'h00, 2);
      obs_q.delete();
      valid_cycles = 0;
   endtask

   task automatic test_clean_scan();
      int first;
      do_reset();
      hold(4'b0001, 7'h3F, 6);
      hold(4'b0010, 7'h06, 6);
      hold(4'b0100, 7'h5B, 6);
      sel_in  = 4'b1000;
      sseg_in = 7'h4F;
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (out_valid && first == 0) first = k;
      end
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (first !== SC + 2) begin
         n_fail++;
         $display("FAIL clean_latency: got %0d expected %0d", first, SC + 2);
      end
      n_checks++;
      if (valid_cycles !== 1) begin
         n_fail++;
         $display("FAIL clean_valid_cycles: got %0d expected 1", valid_cycles);
      end
      n_checks++;
      if (obs_q.size() !== 1 || obs_q[0] !== {4'b0000, 16'h3210}) begin
         n_fail++;
         $display("FAIL clean_frame: got %0d frames, first %h expected 03210",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'h0);
      end
   endtask

   task automatic test_glitch();
      obs_q.delete();
      hold(4'b0001, 7'h7F, 2);
      hold(4'b0001, 7'h6F, 5);
      hold(4'b0010, 7'h06, 6);
      hold(4'b0100, 7'h5B, 6);
      hold(4'b1000, 7'h4F, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (obs_q.size() !== 1 || obs_q[0] !== {4'b0000, 16'h3219}) begin
         n_fail++;
         $display("FAIL glitch_frame: got %0d frames, first %h expected 03219",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'h0);
      end
   endtask

   task automatic test_unknown_blank();
      obs_q.delete();
      hold(4'b0001, 7'h3F, 6);
      hold(4'b0010, 7'h06, 6);
      hold(4'b0100, 7'h55, 5);
      hold(4'b1000, 7'h4F, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL unknown_err: got %b expected 1", err);
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL unknown_noframe: got %0d frames expected 0", obs_q.size());
      end
      hold(4'b0100, 7'h00, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (obs_q.size() !== 1 || obs_q[0] !== {4'b0100, 16'h3010}) begin
         n_fail++;
         $display("FAIL blank_frame: got %0d frames, first %h expected 43010",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'h0);
      end
      n_checks++;
      if (out_blank !== 4'b0100) begin
         n_fail++;
         $display("FAIL blank_flag: got %b expected 0100", out_blank);
      end
      err_clr = 1'b1;
      hold(4'b0000, 7'h00, 1);
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: got %b expected 0", err);
      end
   endtask

   task automatic test_backpressure();
      obs_q.delete();
      out_ready = 1'b0;
      hold(4'b0001, 7'h77, 6);
      hold(4'b0010, 7'h7C, 6);
      hold(4'b0100, 7'h39, 6);
      hold(4'b1000, 7'h5E, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (out_valid !== 1'b1 || out_value !== 16'hDCBA) begin
         n_fail++;
         $display("FAIL bp_first: got valid %b value %h expected 1 DCBA",
                  out_valid, out_value);
      end
      hold(4'b0001, 7'h79, 6);
      hold(4'b0010, 7'h71, 6);
      hold(4'b0100, 7'h3F, 6);
      hold(4'b1000, 7'h06, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (out_valid !== 1'b1 || out_value !== 16'hDCBA) begin
         n_fail++;
         $display("FAIL bp_frozen: got valid %b value %h expected 1 DCBA",
                  out_valid, out_value);
      end
      out_ready = 1'b1;
      hold(4'b0000, 7'h00, 1);
      n_checks++;
      if (out_valid !== 1'b1 || out_value !== 16'h10FE) begin
         n_fail++;
         $display("FAIL bp_next: got valid %b value %h expected 1 10FE",
                  out_valid, out_value);
      end
      hold(4'b0000, 7'h00, 1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drop: got %b expected 0", out_valid);
      end
      n_checks++;
      if (obs_q.size() !== 2 || obs_q[0] !== {4'h0, 16'hDCBA} ||
          obs_q[1] !== {4'h0, 16'h10FE}) begin
         n_fail++;
         $display("FAIL bp_sequence: got %0d frames expected 2 (DCBA, 10FE)",
                  obs_q.size());
      end
   endtask

   task automatic test_illegal_sel();
      obs_q.delete();
      hold(4'b0001, 7'h6D, 6);
      hold(4'b0010, 7'h06, 6);
      hold(4'b0100, 7'h5B, 6);
      hold(4'b0011, 7'h3F, 10);
      hold(4'b0000, 7'h3F, 10);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL illegal_noframe: got %0d frames expected 0", obs_q.size());
      end
      hold(4'b1000, 7'h4F, 6);
      hold(4'b0000, 7'h00, 6);
      n_checks++;
      if (obs_q.size() !== 1 || obs_q[0] !== {4'b0000, 16'h3215}) begin
         n_fail++;
         $display("FAIL illegal_frame: got %0d frames, first %h expected 03215",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'h0);
      end
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_err: got %b expected 0", err);
      end
   endtask

   task automatic test_reset_midframe();
      hold(4'b0001, 7'h3F, 6);
      hold(4'b0010, 7'h06, 6);
      hold(4'b0100, 7'h5B, 6);
      hold(4'b1000, 7'h55, 5);
      do_reset();
      n_checks++;
      if (out_value !== 16'h0 || out_blank !== 4'h0 ||
          out_valid !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h %b %b %b expected 0000 0000 0 0",
                  out_value, out_blank, out_valid, err);
      end
      hold(4'b1000, 7'h4F, 6);
      hold(4'b0000, 7'h00, 10);
      n_checks++;
      if (valid_cycles !== 0) begin
         n_fail++;
         $display("FAIL midreset_noframe: got %0d valid cycles expected 0",
                  valid_cycles);
      end
   endtask

   logic [3:0]  m_val [ND];
   logic        m_blk [ND];
   logic [ND-1:0] m_cap;
   logic        m_err;
   logic [19:0] m_last;
   logic [19:0] exp_q [$];

   task automatic model_episode(input logic [3:0] s, input logic [6:0] g,
                                input int len);
      int d;
      int idx;
      logic [19:0] frame;
      if (!$onehot(s) || len < SC) return;
      d = 0;
      for (int i = 0; i < ND; i++) if (s[i]) d = i;
      idx = -1;
      for (int k = 0; k < 16; k++) if (pat[k] == g) idx = k;
      if (g == 7'h00) begin
         m_val[d] = 4'h0;
         m_blk[d] = 1'b1;
      end else if (idx < 0) begin
         m_err = 1'b1;
         return;
      end else begin
         m_val[d] = 4'(idx);
         m_blk[d] = 1'b0;
      end
      m_cap[d] = 1'b1;
      if (m_cap == '1) begin
         for (int i = 0; i < ND; i++) begin
            frame[4*i +: 4] = m_val[i];
            frame[16 + i]   = m_blk[i];
         end
         m_cap = '0;
`ifdef SSEG_READER_CHANGE_ONLY_EN
         if (frame != m_last) exp_q.push_back(frame);
`else
         exp_q.push_back(frame);
`endif
         m_last = frame;
      end
   endtask

   task automatic test_random();
      logic [3:0] cs, ns;
      logic [6:0] cg, ng;
      int cl, nl, r;
      do_reset();
      m_cap  = '0;
      m_err  = 1'b0;
      m_last = '1;
      exp_q.delete();
      for (int i = 0; i < ND; i++) begin
         m_val[i] = 4'h0;
         m_blk[i] = 1'b0;
      end
      cs = 4'b0000;
      cg = 7'h00;
      cl = 0;
      for (int e = 0; e < 300; e++) begin
         r = int'($urandom_range(0, 99));
         if (r < 80) ns = 4'b0001 << $urandom_range(0, ND - 1);
         else if (r < 90) ns = 4'b0000;
         else ns = 4'($urandom_range(0, 15));
         r = int'($urandom_range(0, 99));
         if (r < 75) ng = pat[$urandom_range(0, 15)];
         else if (r < 85) ng = 7'h00;
         else ng = 7'($urandom_range(0, 127));
         nl = int'($urandom_range(1, 8));
         if (ns == cs && ng == cg) begin
            cl += nl;
         end else begin
            model_episode(cs, cg, cl);
            cs = ns;
            cg = ng;
            cl = nl;
         end
         hold(ns, ng, nl);
      end
      model_episode(cs, cg, cl);
      hold(4'b0000, 7'h00, 12);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d frames expected %0d",
                  obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_frame[%0d]: got %h expected %h",
                     i, obs_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (err !== m_err) begin
         n_fail++;
         $display("FAIL rand_err: got %b expected %b", err, m_err);
      end
   endtask

   initial begin
      reset     = 1'b1;
      sseg_in   = 7'h00;
      sel_in    = 4'b0000;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_clean_scan();
      test_glitch();
      test_unknown_blank();
      test_backpressure();
      test_illegal_sel();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
